// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 128-bit line RAM between the instruction-fetch
// port (I) and the load/store port (D). One transaction is in flight at a time.
// D wins by default. A saturating starvation counter forces an I grant after
// STARVE_LIMIT consecutive D grants taken while I was waiting.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [127:0]      i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [127:0]      d_wdata,
  input  logic [15:0]       d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [127:0]      d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-5:0] m_addr,
  output logic [127:0]      m_wdata,
  output logic [15:0]       m_wstrb,
  input  logic              m_ready,
  input  logic [127:0]      m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t              r_state;
  logic [3:0]          r_starve_cnt;
  logic                r_owner_d;
  logic                r_we;
  logic [ADDR_W-5:0]   r_addr;
  logic [127:0]        r_wdata;
  logic [15:0]         r_wstrb;
  logic                r_i_rvalid;
  logic                r_d_rvalid;
  logic [127:0]        r_i_rdata;
  logic [127:0]        r_d_rdata;

  logic w_idle;
  logic w_starved;
  logic w_d_win;
  logic w_i_win;
  logic w_unused;

  // Line offset bits are irrelevant to a line-granular RAM.
  assign w_unused = &{1'b0, i_addr[3:0], d_addr[3:0]};

  // Arbitration: D by default, I once it has been passed over LIMIT times.
  assign w_idle    = (r_state == S_IDLE);
  assign w_starved = (r_starve_cnt == LIMIT) && i_req;
  assign w_d_win   = d_req && !w_starved;
  assign w_i_win   = i_req && !w_d_win;
  assign i_gnt     = w_idle && w_i_win;
  assign d_gnt     = w_idle && w_d_win;

  assign m_req    = (r_state == S_BUSY);
  assign busy     = (r_state != S_IDLE);
  assign m_we     = r_we;
  assign m_addr   = r_addr;
  assign m_wdata  = r_wdata;
  assign m_wstrb  = r_wstrb;
  assign i_rvalid = r_i_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;

  // Transaction FSM: latch the winner's request, hold it to the RAM, return the response.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_owner_d  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_d_win || w_i_win) begin
            r_owner_d <= w_d_win;
            r_we      <= w_d_win && d_we;
            r_addr    <= w_d_win ? d_addr[ADDR_W-1:4] : i_addr[ADDR_W-1:4];
            r_wdata   <= w_d_win ? d_wdata : '0;
            r_wstrb   <= (w_d_win && d_we) ? d_wstrb : '0;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (m_ready) begin
            r_state <= S_RESP;
            if (r_owner_d) begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= r_we ? '0 : m_rdata;
            end else begin
              r_i_rvalid <= 1'b1;
              r_i_rdata  <= m_rdata;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Starvation counter: counts D grants taken over a waiting I, cleared when I wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_starve_cnt <= 4'd0;
    end else if (i_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (d_gnt && i_req && (r_starve_cnt != LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store ack, contention order,
// starvation release, stray m_ready / dropped request, and reset mid-transaction.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst_n;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [127:0]      i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [127:0]      d_wdata;
  logic [15:0]       d_wstrb;
  logic              d_gnt;
  logic              d_rvalid;
  logic [127:0]      d_rdata;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-5:0] m_addr;
  logic [127:0]      m_wdata;
  logic [15:0]       m_wstrb;
  logic              m_ready;
  logic [127:0]      m_rdata;
  logic              busy;

  int n_checks;
  int n_errs;

  localparam logic [127:0] LINE_F = 128'h021081b3_402000b3_00100113_00000093;
  localparam logic [127:0] JUNK   = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .CLK(clk), .RST_N(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // One zero-wait load transaction starting in an IDLE cycle; reqs stay as given.
  task automatic xact(input logic ireq, input logic dreq, input logic [127:0] line,
                      output logic got_i, output logic got_d);
    i_req = ireq;
    d_req = dreq;
    d_we  = 1'b0;
    #1;
    got_i = i_gnt;
    got_d = d_gnt;
    chk("gnt_excl", got_i & got_d, 0);
    chk("gnt_any", got_i | got_d, 1);
    cyc();
    m_ready = 1'b1;
    m_rdata = line;
    #1;
    chk("busy_no_gnt", {i_gnt, d_gnt}, 0);
    chk("xact_mreq", m_req, 1);
    cyc();
    m_ready = 1'b0;
    #1;
    chk("xact_ivld", i_rvalid, got_i);
    chk("xact_dvld", d_rvalid, got_d);
    chk("xact_rdata", got_i ? i_rdata : d_rdata, line);
    cyc();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mreq"}, m_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ivld"}, i_rvalid, 0);
    chk({tag, "_dvld"}, d_rvalid, 0);
    chk({tag, "_irdata"}, i_rdata, 0);
    chk({tag, "_drdata"}, d_rdata, 0);
    chk({tag, "_maddr"}, m_addr, 0);
    chk({tag, "_mwe"}, m_we, 0);
    chk({tag, "_mwstrb"}, m_wstrb, 0);
    chk({tag, "_mwdata"}, m_wdata, 0);
  endtask

  initial begin
    logic  gi, gd;
    string order;
    n_checks = 0;
    n_errs   = 0;
    rst_n   = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_wstrb = '0;
    m_ready = 1'b0;
    m_rdata = '0;

    // Reset state
    repeat (3) cyc();
    chk_all_zero("rst");
    chk("rst_gnt", {i_gnt, d_gnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Single fetch
    i_req  = 1'b1;
    i_addr = 32'h0000_0010;
    #1;
    chk("f_igntT", i_gnt, 1);
    chk("f_dgntT", d_gnt, 0);
    cyc();
    i_req   = 1'b0;
    m_ready = 1'b1;
    m_rdata = LINE_F;
    #1;
    chk("f_mreq1", m_req, 1);
    chk("f_maddr1", m_addr, 28'h1);
    chk("f_mwstrb1", m_wstrb, 0);
    chk("f_mwe1", m_we, 0);
    chk("f_busy1", busy, 1);
    cyc();
    m_ready = 1'b0;
    #1;
    chk("f_ivld2", i_rvalid, 1);
    chk("f_irdata2", i_rdata, LINE_F);
    chk("f_dvld2", d_rvalid, 0);
    chk("f_mreq2", m_req, 0);
    cyc();
    chk("f_busy3", busy, 0);
    chk("f_ivld3", i_rvalid, 0);
    chk("f_irdhold", i_rdata, LINE_F);

    // Store acknowledged, m_ready three cycles late
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0105;
    d_wstrb = 16'h000F;
    d_wdata = 128'hABABABAB;
    #1;
    chk("s_dgnt", d_gnt, 1);
    chk("s_ignt", i_gnt, 0);
    for (int j = 1; j <= 4; j++) begin
      cyc();
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_wstrb = 16'hFFFF;
      d_wdata = '1;
      m_ready = (j == 4);
      m_rdata = JUNK;
      #1;
      chk($sformatf("s_mreq%0d", j), m_req, 1);
      chk($sformatf("s_maddr%0d", j), m_addr, 28'h10);
      chk($sformatf("s_mwe%0d", j), m_we, 1);
      chk($sformatf("s_mwstrb%0d", j), m_wstrb, 16'h000F);
      chk($sformatf("s_mwdata%0d", j), m_wdata, 128'hABABABAB);
      chk($sformatf("s_dvld%0d", j), d_rvalid, 0);
    end
    cyc();
    m_ready = 1'b0;
    #1;
    chk("s_dvld", d_rvalid, 1);
    chk("s_drdata", d_rdata, 0);
    chk("s_ivld", i_rvalid, 0);
    chk("s_irdhold", i_rdata, LINE_F);
    chk("s_mreq", m_req, 0);
    cyc();

    // Contention: both requests held, LIMIT=4
    order = "DDDDIDDDDI";
    for (int k = 0; k < 10; k++) begin
      xact(1'b1, 1'b1, 128'h1000 + 128'(k), gi, gd);
      chk($sformatf("order%0d_d", k), gd, (order[k] == "D"));
      chk($sformatf("order%0d_i", k), gi, (order[k] == "I"));
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("c_starve0", dut.r_starve_cnt, 0);

    // I alone after starvation
    for (int k = 0; k < 4; k++) begin
      xact(1'b1, 1'b1, 128'h2000 + 128'(k), gi, gd);
      chk($sformatf("st_d%0d", k), gd, 1);
    end
    chk("st_cnt4", dut.r_starve_cnt, 4);
    xact(1'b1, 1'b0, 128'h3000, gi, gd);
    chk("st_igrant", gi, 1);
    chk("st_cnt0", dut.r_starve_cnt, 0);
    i_req = 1'b0;
    d_req = 1'b0;

    // Stray m_ready in IDLE
    m_ready = 1'b1;
    m_rdata = JUNK;
    cyc();
    chk("sr_busy", busy, 0);
    chk("sr_mreq", m_req, 0);
    chk("sr_vld", {i_rvalid, d_rvalid}, 0);
    cyc();
    m_ready = 1'b0;
    chk("sr_busy2", busy, 0);
    chk("sr_irdata", i_rdata, 128'h3000);

    // I request raised and dropped while FSM serves D
    d_req = 1'b1;
    d_we  = 1'b0;
    #1;
    chk("dr_dgnt", d_gnt, 1);
    cyc();
    d_req   = 1'b0;
    i_req   = 1'b1;
    m_ready = 1'b1;
    m_rdata = 128'h4444;
    cyc();
    i_req   = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("dr_dvld", d_rvalid, 1);
    chk("dr_ivld", i_rvalid, 0);
    cyc();
    chk("dr_ignt", i_gnt, 0);
    cyc();
    chk("dr_busy", busy, 0);
    chk("dr_ivld2", i_rvalid, 0);

    // Reset while BUSY
    d_req = 1'b1;
    #1;
    chk("rb_dgnt", d_gnt, 1);
    cyc();
    d_req = 1'b0;
    #1;
    chk("rb_mreq", m_req, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rb");
    cyc();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    m_rdata = JUNK;
    cyc();
    m_ready = 1'b0;
    chk("rb_late_vld", {i_rvalid, d_rvalid}, 0);
    chk("rb_late_busy", busy, 0);
    cyc();
    chk("rb_late_vld2", {i_rvalid, d_rvalid}, 0);
    chk("rb_drdata", d_rdata, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
